// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with optional write bypass and a debug scan engine
// Ports: clock/reset (async, active-low); ctrl_writeEnable/ctrl_writeReg/data_writeReg write port;
//        ctrl_readReg/data_readReg NREAD packed combinational read ports;
//        dbg_start/dbg_ready in, dbg_valid/dbg_index/dbg_data/dbg_busy out for the register scan.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_W-1:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0]        data_writeReg,
  input  logic [NREAD*ADDR_W-1:0] ctrl_readReg,
  output logic [NREAD*WIDTH-1:0]  data_readReg,
  input  logic                    dbg_start,
  input  logic                    dbg_ready,
  output logic                    dbg_valid,
  output logic [ADDR_W-1:0]       dbg_index,
  output logic [WIDTH-1:0]        dbg_data,
  output logic                    dbg_busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [0:0] scan;
  logic [ADDR_W-1:0] idx;
  logic we;
  // Address holds real storage: in range and not the hardwired zero register.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !(ZERO_REG != 0 && a == '0);
  endfunction
  assign we = ctrl_writeEnable && live(ctrl_writeReg);
  always_ff @(posedge clock or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we)
      mem[ctrl_writeReg] <= data_writeReg;
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = ctrl_readReg[p*ADDR_W +: ADDR_W];
    assign data_readReg[p*WIDTH +: WIDTH] = (BYPASS != 0 && we && a == ctrl_writeReg) ? data_writeReg :
                                            live(a) ? mem[a] : '0;
  end
  // idx is only ever nonzero inside SCAN, so IDLE always presents index 0.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      scan <= IDLE;
      idx  <= '0;
    end else if (scan == IDLE) begin
      if (dbg_start) scan <= SCAN;
    end else if (dbg_ready) begin
      scan <= (idx == LAST) ? IDLE : SCAN;
      idx  <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  assign dbg_valid = scan == SCAN;
  assign dbg_busy  = scan == SCAN;
  assign dbg_index = idx;
  assign dbg_data  = (dbg_valid && live(idx)) ? mem[idx] : '0;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (default, no-bypass and DEPTH=24 instances)
module tb_regfile_mp;
  typedef struct {logic [4:0] idx; logic [31:0] data;} beat_t;
  logic clock = 0, reset = 0;
  logic we = 0, dbg_start = 0, dbg_ready = 0;
  logic [4:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0] raddr = '0;
  logic [63:0] rd0, rd1, rd2;
  logic v0, v1, v2, b0, b1, b2;
  logic [4:0] i0, i1, i2;
  logic [31:0] d0, d1, d2;
  logic [31:0] model [32];
  beat_t exp_q[$];
  int n_chk = 0, n_err = 0, vcyc = 0;
  regfile_mp u0 (.clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
    .data_writeReg(wdata), .ctrl_readReg(raddr), .data_readReg(rd0), .dbg_start(dbg_start),
    .dbg_ready(dbg_ready), .dbg_valid(v0), .dbg_index(i0), .dbg_data(d0), .dbg_busy(b0));
  regfile_mp #(.BYPASS(0)) u1 (.clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
    .data_writeReg(wdata), .ctrl_readReg(raddr), .data_readReg(rd1), .dbg_start(dbg_start),
    .dbg_ready(dbg_ready), .dbg_valid(v1), .dbg_index(i1), .dbg_data(d1), .dbg_busy(b1));
  regfile_mp #(.DEPTH(24)) u2 (.clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
    .data_writeReg(wdata), .ctrl_readReg(raddr), .data_readReg(rd2), .dbg_start(dbg_start),
    .dbg_ready(dbg_ready), .dbg_valid(v2), .dbg_index(i2), .dbg_data(d2), .dbg_busy(b2));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // Model and queued beats change only once the write has committed on the edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
    if (a != 0) begin
      model[a] = d;
      foreach (exp_q[k]) if (exp_q[k].idx == a) exp_q[k].data = d;
    end
  endtask
  task automatic start_scan();
    for (int i = 0; i < 32; i++) exp_q.push_back('{idx: 5'(i), data: model[i]});
    dbg_start = 1;
    tick();
    dbg_start = 0;
  endtask
  task automatic wait_idx(input logic [4:0] i);
    int k = 0;
    while (!(v0 && i0 == i) && k < 200) begin tick(); k++; end
    check("wait_idx_bound", 32'(k < 200), 1);
  endtask
  task automatic wait_empty();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin tick(); k++; end
    check("wait_empty_bound", 32'(k < 200), 1);
  endtask
  always @(negedge clock)
    if (reset && v0) begin
      vcyc++;
      check("scan_busy", 32'(b0), 1);
      if (exp_q.size() == 0) check("scan_extra_beat", 32'(v0), 0);
      else begin
        check("scan_index", 32'(i0), 32'(exp_q[0].idx));
        check("scan_data", d0, exp_q[0].data);
        if (dbg_ready) void'(exp_q.pop_front());
      end
    end
  initial begin
    foreach (model[k]) model[k] = '0;
    tick(); tick();
    check("rst_valid", 32'(v0), 0);
    check("rst_busy", 32'(b0), 0);
    check("rst_index", 32'(i0), 0);
    check("rst_data", d0, 0);
    raddr = {5'd5, 5'd5};
    #1 check("rst_read", rd0[31:0], 0);
    reset = 1;
    tick();
    wr(5, 32'hDEADBEEF);
    #1 check("rd_p0_r5", rd0[31:0], 32'hDEADBEEF);
    check("rd_p1_r5", rd0[63:32], 32'hDEADBEEF);
    wr(0, 32'h1234);
    raddr = {5'd5, 5'd0};
    #1 check("rd_r0_zero", rd0[31:0], 0);
    check("rd_p1_indep", rd0[63:32], 32'hDEADBEEF);
    we = 1; waddr = 7; wdata = 32'hA5A5A5A5; raddr = {5'd5, 5'd7};
    #1 check("bypass_on", rd0[31:0], 32'hA5A5A5A5);
    check("bypass_off", rd1[31:0], 0);
    tick();
    we = 0; model[7] = 32'hA5A5A5A5;
    #1 check("after_wr_r7", rd1[31:0], 32'hA5A5A5A5);
    wr(30, 32'hFFFF);
    raddr = {5'd5, 5'd30};
    #1 check("d24_r30_dropped", rd2[31:0], 0);
    check("d32_r30", rd0[31:0], 32'hFFFF);
    for (int i = 0; i < 24; i++) begin
      raddr = {5'd0, 5'(i)};
      #1 check("d24_unchanged", rd2[31:0], model[i]);
    end
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) + 32'h100);
    check("model_r0", model[0], 0);
    dbg_ready = 1; vcyc = 0;
    start_scan();
    wait_empty();
    tick();
    check("scan_len", 32'(vcyc), 32);
    check("scan_end_valid", 32'(v0), 0);
    dbg_ready = 0;
    start_scan();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin dbg_ready = ~dbg_ready; tick(); end
    check("toggle_done", 32'(exp_q.size()), 0);
    dbg_ready = 1;
    tick();
    start_scan();
    wait_idx(3);
    dbg_ready = 0;
    wr(3, 32'h77);
    #1 check("held_idx", 32'(i0), 3);
    check("held_data", d0, 32'h77);
    dbg_start = 1;
    tick();
    dbg_start = 0;
    check("no_restart_idx", 32'(i0), 3);
    dbg_ready = 1;
    wait_empty();
    tick();
    start_scan();
    wait_idx(31);
    dbg_start = 1;
    tick();
    dbg_start = 0;
    check("last_start_idle", 32'(v0), 0);
    check("last_start_q", 32'(exp_q.size()), 0);
    tick();
    check("last_start_idle2", 32'(v0), 0);
    start_scan();
    wait_idx(10);
    #2 reset = 0;
    #1 check("async_valid", 32'(v0), 0);
    check("async_busy", 32'(b0), 0);
    exp_q.delete();
    foreach (model[k]) model[k] = '0;
    tick();
    reset = 1;
    for (int i = 0; i < 32; i += 4) begin
      raddr = {5'(i + 1), 5'(i)};
      #1 check("post_rst_p0", rd0[31:0], 0);
      check("post_rst_p1", rd0[63:32], 0);
    end
    tick(); tick();
    check("post_rst_valid", 32'(v0), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
